// File: rtl/led_fade_if.sv
// LED fade driver signal bundle: pattern/control toward the driver, PWM drive and
// status back out. The driver itself has no bus of its own; this bundle just keeps
// the board-facing signals together.
interface led_fade_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] pattern_in;
  logic             enable;
  logic             fade_bypass;
  logic [WIDTH-1:0] led_out;
  logic             busy;

  modport master (
    output pattern_in,
    output enable,
    output fade_bypass,
    input  led_out,
    input  busy
  );

  modport slave (
    input  pattern_in,
    input  enable,
    input  fade_bypass,
    output led_out,
    output busy
  );
endinterface

// File: rtl/led_fade_driver.sv
// LED fade driver: synchronises the PIO LED pattern, ramps a per-channel brightness
// level toward full on/off one step per prescaler tick, and turns each level into a
// PWM drive whose high time per period equals the level.
module led_fade_driver #(
  parameter int WIDTH    = 8,
  parameter int PWM_BITS = 8,
  parameter int STEP_DIV = 19531
) (
  input  logic       clk,
  input  logic       reset_n,
  led_fade_if.slave  bus
);

  localparam int                   PRE_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRE_W-1:0]     PRE_LAST = PRE_W'(STEP_DIV - 1);
  localparam logic [PWM_BITS-1:0]  LVL_MAX  = '1;
  localparam logic [PWM_BITS-1:0]  PWM_LAST = LVL_MAX - PWM_BITS'(1);

  logic [WIDTH-1:0]                sync_p0;
  logic [WIDTH-1:0]                target_p1;
  logic [PRE_W-1:0]                pre_cnt;
  logic [PWM_BITS-1:0]             pwm_cnt;
  logic [WIDTH-1:0][PWM_BITS-1:0]  level_p2;
  logic [WIDTH-1:0]                led_next;
  logic [WIDTH-1:0]                led_p3;
  logic                            step_tick;
  logic                            busy_c;

  // One brightness step toward the target extreme, saturating at 0 and MAX.
  function automatic logic [PWM_BITS-1:0] step_level(input logic [PWM_BITS-1:0] lvl,
                                                      input logic              tgt);
    logic [PWM_BITS-1:0] res;
    res = lvl;
    if (tgt && (lvl != LVL_MAX))
      res = lvl + PWM_BITS'(1);
    else if (!tgt && (lvl != '0))
      res = lvl - PWM_BITS'(1);
    return res;
  endfunction

  // Stage p0/p1: two-flop synchroniser bringing the PIO pattern into this clock domain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_p0   <= '0;
      target_p1 <= '0;
    end else begin
      sync_p0   <= bus.pattern_in;
      target_p1 <= sync_p0;
    end
  end

  // Step prescaler: wraps every STEP_DIV cycles, parked at 0 while disabled so the
  // first step after re-enable lands a full STEP_DIV cycles later.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pre_cnt <= '0;
    else if (!bus.enable || (pre_cnt == PRE_LAST))
      pre_cnt <= '0;
    else
      pre_cnt <= pre_cnt + PRE_W'(1);
  end

  assign step_tick = bus.enable && (pre_cnt == PRE_LAST);

  // PWM phase counter: period of MAX cycles so level L gives exactly L high cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pwm_cnt <= '0;
    else if (!bus.enable || (pwm_cnt == PWM_LAST))
      pwm_cnt <= '0;
    else
      pwm_cnt <= pwm_cnt + PWM_BITS'(1);
  end

  // Stage p2: per-channel brightness; bypass snaps to the extreme, otherwise one step
  // per tick. A target flip mid-ramp simply reverses from the current level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_p2 <= '0;
    end else if (bus.enable) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (bus.fade_bypass)
          level_p2[i] <= target_p1[i] ? LVL_MAX : '0;
        else if (step_tick)
          level_p2[i] <= step_level(level_p2[i], target_p1[i]);
      end
    end
  end

  // PWM compare for every channel, blanked when disabled.
  always_comb begin
    led_next = '0;
    for (int i = 0; i < WIDTH; i++)
      led_next[i] = bus.enable && (level_p2[i] > pwm_cnt);
  end

  // Stage p3: registered LED drive.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      led_p3 <= '0;
    else
      led_p3 <= led_next;
  end

  // Busy while any channel has not yet settled at its target extreme.
  always_comb begin
    busy_c = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      if (level_p2[i] != (target_p1[i] ? LVL_MAX : '0))
        busy_c = 1'b1;
  end

  assign bus.led_out = led_p3;
  assign bus.busy    = busy_c;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed bench for led_fade_driver: reset, ramp up, mid-ramp reversal, enable
// freeze/resume, bypass snap, reset mid-activity and PWM duty at a fixed level.
module tb_led_fade_driver;

  logic clk;
  logic reset_n;
  int   checks;
  int   failures;
  int   n;
  int   ones;
  int   maxl;
  int   prev;
  int   cur;
  int   bad;
  int   busy_bad;

  led_fade_if #(.WIDTH(8)) bus ();
  led_fade_if #(.WIDTH(8)) bus64 ();

  led_fade_driver #(.WIDTH(8), .PWM_BITS(4), .STEP_DIV(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  led_fade_driver #(.WIDTH(8), .PWM_BITS(4), .STEP_DIV(64)) dut64 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    bus.pattern_in    = 8'h00;
    bus.enable        = 1'b0;
    bus.fade_bypass   = 1'b0;
    bus64.pattern_in  = 8'h00;
    bus64.enable      = 1'b0;
    bus64.fade_bypass = 1'b0;
    repeat (3) step();
    chk("rst_led", int'(bus.led_out), 0);
    chk("rst_busy", int'(bus.busy), 0);

    reset_n    = 1'b1;
    bus.enable = 1'b1;
    repeat (5) step();

    // ramp up on channel 0
    bus.pattern_in = 8'h01;
    n = 0;
    while (dut.level_p2[0] == 4'd0 && n < 12) begin step(); n++; end
    chk("up_first_level", int'(dut.level_p2[0]), 1);
    chk("up_first_within6", int'(n >= 3 && n <= 6), 1);
    chk("up_busy", int'(bus.busy), 1);
    repeat (4) step();
    chk("up_second_step", int'(dut.level_p2[0]), 2);
    n = 4;
    while (dut.level_p2[0] != 4'd15 && n < 80) begin step(); n++; end
    chk("up_full_cycles", n, 56);
    chk("up_busy_clear", int'(bus.busy), 0);
    step();
    ones = 0;
    repeat (16) begin ones += int'(bus.led_out[0]); step(); end
    chk("up_led_on", ones, 16);
    chk("up_other_leds", int'(bus.led_out[7:1]), 0);

    // bypass back to zero, then reverse a rising ramp at level 7
    bus.fade_bypass = 1'b1;
    bus.pattern_in  = 8'h00;
    repeat (4) step();
    chk("byp_clear", int'(dut.level_p2[0]), 0);
    bus.fade_bypass = 1'b0;
    bus.pattern_in  = 8'h01;
    n = 0;
    while (dut.level_p2[0] != 4'd7 && n < 60) begin step(); n++; end
    chk("rev_reach7", int'(dut.level_p2[0]), 7);
    bus.pattern_in = 8'h00;
    maxl = 7; prev = 7; bad = 0; busy_bad = 0; n = 0;
    while (dut.level_p2[0] != 4'd0 && n < 60) begin
      step();
      n++;
      cur = int'(dut.level_p2[0]);
      if (cur > maxl) maxl = cur;
      if (cur != prev && cur != prev - 1) bad++;
      if (cur != 0 && !bus.busy) busy_bad++;
      prev = cur;
    end
    chk("rev_max", maxl, 7);
    chk("rev_steps", bad, 0);
    chk("rev_busy_held", busy_bad, 0);
    chk("rev_cycles", n, 28);
    chk("rev_busy_clear", int'(bus.busy), 0);
    step();
    ones = 0;
    repeat (16) begin ones += int'(bus.led_out[0]); step(); end
    chk("rev_led_off", ones, 0);

    // enable freeze at level 9 and resume
    bus.pattern_in = 8'h01;
    n = 0;
    while (dut.level_p2[0] != 4'd9 && n < 80) begin step(); n++; end
    chk("en_reach9", int'(dut.level_p2[0]), 9);
    bus.enable = 1'b0;
    step();
    chk("en_led_blank", int'(bus.led_out), 0);
    chk("en_busy", int'(bus.busy), 1);
    repeat (10) step();
    chk("en_level_hold", int'(dut.level_p2[0]), 9);
    chk("en_led_still", int'(bus.led_out), 0);
    bus.enable = 1'b1;
    repeat (3) step();
    chk("en_no_early_step", int'(dut.level_p2[0]), 9);
    step();
    chk("en_resume", int'(dut.level_p2[0]), 10);

    // bypass snap to 0xA5
    bus.fade_bypass = 1'b1;
    bus.pattern_in  = 8'hA5;
    repeat (2) step();
    chk("byp_lvl2_c2", int'(dut.level_p2[2]), 0);
    step();
    chk("byp_lvl0", int'(dut.level_p2[0]), 15);
    chk("byp_lvl1", int'(dut.level_p2[1]), 0);
    chk("byp_lvl2", int'(dut.level_p2[2]), 15);
    chk("byp_lvl6", int'(dut.level_p2[6]), 0);
    chk("byp_lvl7", int'(dut.level_p2[7]), 15);
    chk("byp_busy", int'(bus.busy), 0);
    step();
    chk("byp_led", int'(bus.led_out), 8'hA5);

    // asynchronous reset in the middle of activity
    repeat (2) step();
    reset_n = 1'b0;
    #1;
    chk("rst_mid_led", int'(bus.led_out), 0);
    chk("rst_mid_busy", int'(bus.busy), 0);
    chk("rst_mid_level", int'(dut.level_p2[0]), 0);
    repeat (3) step();
    chk("rst_hold_led", int'(bus.led_out), 0);
    chk("rst_hold_busy", int'(bus.busy), 0);
    bus.fade_bypass = 1'b0;
    bus.pattern_in  = 8'h00;
    bus.enable      = 1'b0;
    reset_n = 1'b1;
    step();

    // duty at level 5 with STEP_DIV=64
    bus64.enable     = 1'b1;
    bus64.pattern_in = 8'h08;
    n = 0;
    while (dut64.level_p2[3] != 4'd5 && n < 500) begin step(); n++; end
    chk("duty_reach5", int'(dut64.level_p2[3]), 5);
    step();
    ones = 0;
    repeat (15) begin ones += int'(bus64.led_out[3]); step(); end
    chk("duty_high5", ones, 5);
    chk("duty_level_held", int'(dut64.level_p2[3]), 5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
